btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer for the BPU, successor to the direct-mapped BTB. It adds configurable associativity, a 2-bit saturating direction counter per entry, per-set round-robin replacement, a registered lookup response, and a global flush. It sits in the fetch stage: the PC is looked up in cycle t, and the prediction is consumed by next-PC select in cycle t+1. It is updated from the branch-resolve stage.

---
 rtl/btb_assoc.sv | 141 ++++++++++++++
 tb/tb_btb_assoc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer with 2-bit direction counters
// Registered lookup, round-robin replacement per set, global flush.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module btb_assoc #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lk_valid,
  input  logic [ADDR_WIDTH-1:0] lk_pc,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic                  rsp_taken,
  output logic [ADDR_WIDTH-1:0] rsp_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_taken
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int TGT_W = ADDR_WIDTH - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TGT_W-1:0] tgt_q   [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];

  logic             lk_hit;
  logic [TGT_W-1:0] lk_tgt;
  logic [1:0]       lk_ctr;

  // Allocation never duplicates a tag, so at most one way can match.
  always_comb begin
    lk_hit = 1'b0;
    lk_tgt = '0;
    lk_ctr = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_tgt = tgt_q[lk_idx][w];
        lk_ctr = ctr_q[lk_idx][w];
      end
    end
  end

  logic             upd_hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, wr_way, rr_next;
  logic [1:0]       ctr_cur, ctr_next;
  logic             upd_en, do_hit, do_alloc;

  always_comb begin
    upd_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan leaves the lowest-index invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[upd_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign upd_en   = upd_valid && !flush;
  assign do_hit   = upd_en && upd_hit;
  assign do_alloc = upd_en && !upd_hit && upd_taken;
  assign wr_way   = upd_hit ? hit_way : (inv_found ? inv_way : rr_q[upd_idx]);
  assign rr_next  = (rr_q[upd_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[upd_idx] + 1'b1;
  assign ctr_cur  = ctr_q[upd_idx][hit_way];

  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != 2'd3) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_next = ctr_cur - 2'd1;
    end
  end

  // Payload needs no reset: valid gates every use of it.
  always_ff @(posedge clk) begin
    if (!rst && (do_hit || do_alloc)) begin
      ctr_q[upd_idx][wr_way] <= do_alloc ? 2'b10 : ctr_next;
      if (upd_taken) tgt_q[upd_idx][wr_way] <= upd_target[ADDR_WIDTH-1:2];
      if (do_alloc) tag_q[upd_idx][wr_way] <= upd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_target <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      rsp_valid  <= lk_valid;
      rsp_hit    <= lk_valid && lk_hit;
      rsp_taken  <= lk_valid && lk_hit && lk_ctr[1];
      rsp_target <= (lk_valid && lk_hit) ? {lk_tgt, 2'b00} : '0;
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else if (do_alloc) begin
        valid_q[upd_idx][wr_way] <= 1'b1;
        if (!inv_found) rr_q[upd_idx] <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - scoreboard bench for btb_assoc (2-way/64-set and 1-way/16-set)
// Shared stimulus drives both configurations; each has its own reference model and queue.
module tb_btb_assoc;

  bit clk;
  always #5 clk = ~clk;

  logic        rst, flush, lk_valid, upd_valid, upd_taken;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        r0_valid, r0_hit, r0_taken, r1_valid, r1_hit, r1_taken;
  logic [31:0] r0_target, r1_target;

  btb_assoc #(.ADDR_WIDTH(32), .SETS(64), .WAYS(2)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .rsp_valid(r0_valid), .rsp_hit(r0_hit), .rsp_taken(r0_taken), .rsp_target(r0_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  btb_assoc #(.ADDR_WIDTH(32), .SETS(16), .WAYS(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .rsp_valid(r1_valid), .rsp_hit(r1_hit), .rsp_taken(r1_taken), .rsp_target(r1_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  typedef struct packed {
    logic        v;
    logic        h;
    logic        t;
    logic [31:0] tg;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: plain arrays of entries, indexed [config][set][way].
  int          m_sets[2] = '{64, 16};
  int          m_ways[2] = '{2, 1};
  int          m_lg[2]   = '{6, 4};
  bit          mv   [2][64][8];
  logic [31:0] mtag [2][64][8];
  logic [31:0] mtgt [2][64][8];
  int          mctr [2][64][8];
  int          mrr  [2][64];

  function automatic int midx(int m, logic [31:0] pc);
    return int'((pc >> 2) % 32'(m_sets[m]));
  endfunction

  function automatic logic [31:0] mtg(int m, logic [31:0] pc);
    return pc >> (2 + m_lg[m]);
  endfunction

  task automatic m_clear();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < 64; s++) begin
        mrr[m][s] = 0;
        for (int w = 0; w < 8; w++) mv[m][s][w] = 1'b0;
      end
  endtask

  function automatic rsp_t m_look(int m, logic [31:0] pc);
    rsp_t r;
    int   s;
    r = '0;
    r.v = 1'b1;
    s = midx(m, pc);
    for (int w = 0; w < m_ways[m]; w++)
      if (mv[m][s][w] && mtag[m][s][w] == mtg(m, pc)) begin
        r.h  = 1'b1;
        r.t  = (mctr[m][s][w] >= 2);
        r.tg = mtgt[m][s][w];
      end
    return r;
  endfunction

  task automatic m_update(int m, logic [31:0] pc, logic [31:0] tgt, logic tk);
    int s, hw, v;
    s  = midx(m, pc);
    hw = -1;
    for (int w = 0; w < m_ways[m]; w++)
      if (mv[m][s][w] && mtag[m][s][w] == mtg(m, pc)) hw = w;
    if (hw >= 0) begin
      if (tk) begin
        mctr[m][s][hw] = (mctr[m][s][hw] == 3) ? 3 : mctr[m][s][hw] + 1;
        mtgt[m][s][hw] = tgt & 32'hFFFF_FFFC;
      end else begin
        mctr[m][s][hw] = (mctr[m][s][hw] == 0) ? 0 : mctr[m][s][hw] - 1;
      end
    end else if (tk) begin
      v = -1;
      for (int w = m_ways[m] - 1; w >= 0; w--)
        if (!mv[m][s][w]) v = w;
      if (v < 0) begin
        v = mrr[m][s];
        mrr[m][s] = (mrr[m][s] + 1) % m_ways[m];
      end
      mv[m][s][v]   = 1'b1;
      mtag[m][s][v] = mtg(m, pc);
      mtgt[m][s][v] = tgt & 32'hFFFF_FFFC;
      mctr[m][s][v] = 2;
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic lv, input logic [31:0] lp,
                     input logic uv, input logic [31:0] up, input logic [31:0] ut, input logic tk);
    rsp_t e0, e1;
    rst = r; flush = f; lk_valid = lv; lk_pc = lp;
    upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
    e0 = '0;
    e1 = '0;
    if (!r && lv) begin
      e0 = m_look(0, lp);
      e1 = m_look(1, lp);
    end
    q0.push_back(e0);
    q1.push_back(e1);
    if (r || f) m_clear();
    else if (uv) begin
      m_update(0, up, ut, tk);
      m_update(1, up, ut, tk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input logic [31:0] pc);
    cyc(1'b0, 1'b0, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic up(input logic [31:0] pc, input logic [31:0] t, input logic tk);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, pc, t, tk);
  endtask

  always @(negedge clk) begin
    rsp_t e, a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {r0_valid, r0_hit, r0_taken, r0_target};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL rsp_w2 t=%0t: got v=%0b h=%0b t=%0b tgt=%h, want v=%0b h=%0b t=%0b tgt=%h",
                 $time, a.v, a.h, a.t, a.tg, e.v, e.h, e.t, e.tg);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {r1_valid, r1_hit, r1_taken, r1_target};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL rsp_w1 t=%0t: got v=%0b h=%0b t=%0b tgt=%h, want v=%0b h=%0b t=%0b tgt=%h",
                 $time, a.v, a.h, a.t, a.tg, e.v, e.h, e.t, e.tg);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] lp, upc, ut;
    logic        r, f, lv, uv, tk;
    m_clear();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0);
    lk(32'h1000);
    // Lookup alongside the first taken update sees pre-update state.
    cyc(1'b0, 1'b0, 1'b1, 32'h1000, 1'b1, 32'h1000, 32'h2004, 1'b1);
    lk(32'h1000);
    up(32'h1000, 32'h2004, 1'b0);
    up(32'h1000, 32'h2004, 1'b0);
    lk(32'h1000);
    up(32'h0000, 32'h100, 1'b1);
    up(32'h0100, 32'h200, 1'b1);
    up(32'h0200, 32'h300, 1'b1);
    lk(32'h0000); lk(32'h0100); lk(32'h0200);
    up(32'h0300, 32'h400, 1'b1);
    lk(32'h0100); lk(32'h0200); lk(32'h0300);
    for (int i = 0; i < 5; i++) up(32'h1000, 32'h2004, 1'b1);
    lk(32'h1000);
    up(32'h1000, 32'h2004, 1'b0);
    lk(32'h1000);
    up(32'h1000, 32'h2004, 1'b0);
    lk(32'h1000);
    up(32'h0104, 32'h1111, 1'b1);
    up(32'h0208, 32'h2223, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 32'h1000, 1'b1, 32'h3000, 32'h3100, 1'b1);
    lk(32'h3000); lk(32'h1000); lk(32'h0104); lk(32'h0208);
    up(32'h1000, 32'h2004, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0);
    lk(32'h1000);
    up(32'h0000, 32'h500, 1'b1);
    up(32'h0040, 32'h600, 1'b1);
    lk(32'h0000); lk(32'h0040);
    cyc(1'b0, 1'b0, 1'b0, 32'h0040, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      lp  = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      ut  = $urandom;
      r   = ($urandom_range(0, 255) == 0);
      f   = ($urandom_range(0, 63) == 0);
      lv  = 1'($urandom_range(0, 1));
      uv  = 1'($urandom_range(0, 1));
      tk  = ($urandom_range(0, 2) != 0);
      cyc(r, f, lv, lp, uv, upc, ut, tk);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses outstanding, want 0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
